// File: rtl/tern_pkg.sv
// -----------------------------------------------------------------------------
// tern_pkg
// Shared definitions for the ternary-to-binary converter:
//   - 2-bit trit encodings (TRIT_0 / TRIT_1 / TRIT_2 / TRIT_ILL)
//   - converter FSM state enum (IDLE / CONV / DONE)
// No ports (package).
// -----------------------------------------------------------------------------
package tern_pkg;

    // Trit encoding: high bit at [2i+1], low bit at [2i].
    localparam logic [1:0] TRIT_0   = 2'b00;
    localparam logic [1:0] TRIT_1   = 2'b01;
    localparam logic [1:0] TRIT_2   = 2'b10;
    localparam logic [1:0] TRIT_ILL = 2'b11;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CONV = 2'd1,
        DONE = 2'd2
    } state_t;

endpackage : tern_pkg

// File: rtl/tern_digit_mac.sv
// -----------------------------------------------------------------------------
// tern_digit_mac
// One Horner step of the ternary-to-binary conversion: next_acc = acc*3 + trit,
// built from a shift and two adds (no multiplier).
//
// Configuration macro: TERN2BIN_ERRCHK_EN
//   defined   : code 11 contributes 0 and raises ill
//   undefined : code 11 contributes 2 (high bit dominant), ill is tied 0
//
// Ports
//   acc      in  [BW-1:0]  accumulator before this digit
//   trit     in  [1:0]     encoded trit
//   next_acc out [BW-1:0]  acc*3 + digit value
//   ill      out           trit carried the illegal code (check build only)
// -----------------------------------------------------------------------------
module tern_digit_mac
    import tern_pkg::*;
#(
    parameter int BW = 8
) (
    input  logic [BW-1:0] acc,
    input  logic [1:0]    trit,
    output logic [BW-1:0] next_acc,
    output logic          ill
);

    logic [1:0] digit;

    always_comb begin
        // NOTE: every output of a combinational block gets a default first so
        // no path through the case can leave it unassigned and infer a latch.
        digit = 2'd0;
        ill   = 1'b0;
        case (trit)
            TRIT_0:  digit = 2'd0;
            TRIT_1:  digit = 2'd1;
            TRIT_2:  digit = 2'd2;
            default: begin
`ifdef TERN2BIN_ERRCHK_EN
                digit = 2'd0;
                ill   = 1'b1;
`else
                // High bit dominates: 11 reads as 2.
                digit = 2'd2;
`endif
            end
        endcase
    end

    // acc*3 == (acc << 1) + acc; overflow cannot occur for legal words since
    // 2^BW >= 3^NTRIT.
    assign next_acc = (acc << 1) + acc + BW'(digit);

endmodule : tern_digit_mac

// File: rtl/tern2bin.sv
// -----------------------------------------------------------------------------
// tern2bin
// Serial ternary-to-binary converter with valid/ready handshakes on both sides.
// A captured word of NTRIT trits is folded MSB-first into a binary accumulator,
// one trit per cycle, then presented until the consumer takes it.
//
// Configuration macro: TERN2BIN_ERRCHK_EN (illegal-trit detection, out_err).
//
// Ports
//   clk        in                 rising-edge clock
//   rst        in                 asynchronous, active-high reset
//   in_valid   in                 producer presents a word on in_trits
//   in_ready   out                converter idle and able to capture a word
//   in_trits   in  [2*NTRIT-1:0]  trit i at [2i+1:2i]
//   out_valid  out                out_bin/out_err hold a finished conversion
//   out_ready  in                 consumer accepts the result
//   out_bin    out [BW-1:0]       binary value of the captured word
//   out_err    out                captured word had an illegal trit
// -----------------------------------------------------------------------------
module tern2bin
    import tern_pkg::*;
#(
    parameter int NTRIT = 5,
    parameter int BW    = 8
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               in_valid,
    output logic               in_ready,
    input  logic [2*NTRIT-1:0] in_trits,
    output logic               out_valid,
    input  logic               out_ready,
    output logic [BW-1:0]      out_bin,
    output logic               out_err
);

    localparam int CW = (NTRIT > 1) ? $clog2(NTRIT) : 1;

    state_t               state;
    state_t               state_nxt;
    logic [2*NTRIT-1:0]   shreg;
    logic [BW-1:0]        acc;
    logic [BW-1:0]        mac_out;
    logic [CW-1:0]        cnt;
    logic                 digit_ill;
    logic                 accept;
    logic                 last_step;
    logic                 out_fire;

    assign accept    = in_valid && in_ready;
    assign last_step = (state == CONV) && (cnt == '0);
    assign out_fire  = out_valid && out_ready;

    // The current digit is always the top trit of the shift register.
    tern_digit_mac #(
        .BW (BW)
    ) u_mac (
        .acc      (acc),
        .trit     (shreg[2*NTRIT-1 -: 2]),
        .next_acc (mac_out),
        .ill      (digit_ill)
    );

    // ------------------------------------------------------------------ FSM
    always_ff @(posedge clk or posedge rst) begin
        // NOTE: sequential state uses non-blocking assignments so every
        // register samples pre-edge values, independent of statement order.
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (accept)    state_nxt = CONV;
            CONV:    if (last_step) state_nxt = DONE;
            DONE:    if (out_fire)  state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_comb begin
        // Reset is asynchronous, so in_ready must also drop combinationally
        // while rst is held rather than waiting for an edge.
        in_ready  = (state == IDLE) && !rst;
        out_valid = (state == DONE);
    end

    // ------------------------------------------------------------- datapath
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            shreg   <= '0;
            acc     <= '0;
            cnt     <= '0;
            out_bin <= '0;
        end else begin
            if (accept) begin
                shreg <= in_trits;
                acc   <= '0;
                cnt   <= CW'(NTRIT - 1);
            end else if (state == CONV) begin
                acc   <= mac_out;
                shreg <= shreg << 2;
                if (cnt != '0) begin
                    cnt <= cnt - 1'b1;
                end
                // The result register moves only on the CONV->DONE step.
                if (last_step) begin
                    out_bin <= mac_out;
                end
            end
        end
    end

`ifdef TERN2BIN_ERRCHK_EN
    logic err_flag;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            err_flag <= 1'b0;
            out_err  <= 1'b0;
        end else begin
            if (accept) begin
                err_flag <= 1'b0;
            end else if (state == CONV) begin
                err_flag <= err_flag | digit_ill;
                // Fold in the final digit's flag as it is consumed.
                if (last_step) begin
                    out_err <= err_flag | digit_ill;
                end
            end
        end
    end
`else
    // Without checking the MAC ties its flag to 0, so this is a constant 0.
    assign out_err = digit_ill;
`endif

endmodule : tern2bin

// File: tb/tb_tern2bin.sv
// -----------------------------------------------------------------------------
// tb_tern2bin
// Self-checking bench for tern2bin. A negedge monitor compares every cycle's
// handshake and result outputs against a scoreboard of expected conversions;
// directed tasks add literal expectations for the named vectors.
// Honours TERN2BIN_ERRCHK_EN the same way as the design.
// -----------------------------------------------------------------------------
module tb_tern2bin;

    localparam int NTRIT = 5;
    localparam int BW    = 8;

    logic               clk = 1'b0;
    logic               rst;
    logic               in_valid;
    logic               in_ready;
    logic [2*NTRIT-1:0] in_trits;
    logic               out_valid;
    logic               out_ready;
    logic [BW-1:0]      out_bin;
    logic               out_err;

    tern2bin #(
        .NTRIT (NTRIT),
        .BW    (BW)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_trits  (in_trits),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_bin   (out_bin),
        .out_err   (out_err)
    );

    always #5 clk = ~clk;

    int tests = 0;
    int fails = 0;
    int cyc   = 0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        tests++;
        if (got !== exp) begin
            fails++;
            $display("FAIL %s: got %0d, expected %0d (cycle %0d)", name, got, exp, cyc);
        end
    endtask

    // ------------------------------------------------------------ model
    function automatic logic [2*NTRIT-1:0] pack5(input int t4, input int t3, input int t2,
                                                 input int t1, input int t0);
        return {t4[1:0], t3[1:0], t2[1:0], t1[1:0], t0[1:0]};
    endfunction

    function automatic int model_bin(input logic [2*NTRIT-1:0] w);
        int v;
        int d;
        v = 0;
        for (int i = NTRIT - 1; i >= 0; i--) begin
            d = int'(w[2*i +: 2]);
            if (d == 3) begin
`ifdef TERN2BIN_ERRCHK_EN
                d = 0;
`else
                d = 2;
`endif
            end
            v = v * 3 + d;
        end
        return v;
    endfunction

    function automatic int model_err(input logic [2*NTRIT-1:0] w);
        int e;
        e = 0;
`ifdef TERN2BIN_ERRCHK_EN
        for (int i = 0; i < NTRIT; i++) begin
            if (w[2*i +: 2] == 2'b11) e = 1;
        end
`endif
        return e;
    endfunction

    typedef struct {
        int bin;
        int err;
        int acc_edge;
    } exp_t;

    exp_t q[$];
    int   last_bin = 0;
    int   last_err = 0;

    // One compare process: expected outputs derive from the scoreboard only.
    always @(negedge clk) begin
        logic exp_v;
        if (rst) begin
            q.delete();
            last_bin = 0;
            last_err = 0;
        end
        check("mon_in_ready", in_ready, (!rst && q.size() == 0));
        exp_v = (q.size() > 0) && (cyc >= q[0].acc_edge + NTRIT);
        check("mon_out_valid", out_valid, exp_v);
        if (exp_v) begin
            check("mon_out_bin", out_bin, q[0].bin);
            check("mon_out_err", out_err, q[0].err);
        end else begin
            check("mon_hold_bin", out_bin, last_bin);
            check("mon_hold_err", out_err, last_err);
        end
        if (in_valid && in_ready && !rst) begin
            q.push_back('{bin: model_bin(in_trits), err: model_err(in_trits), acc_edge: cyc + 1});
        end
        if (out_valid && out_ready && exp_v) begin
            last_bin = q[0].bin;
            last_err = q[0].err;
            void'(q.pop_front());
        end
    end

    // ------------------------------------------------------------ drivers
    task automatic send(input logic [2*NTRIT-1:0] w);
        bit ok;
        ok = 1'b0;
        @(posedge clk);
        #1;
        in_valid = 1'b1;
        in_trits = w;
        for (int i = 0; i < 50; i++) begin
            @(negedge clk);
            if (in_ready) begin
                ok = 1'b1;
                break;
            end
        end
        if (!ok) check("send_timeout", 0, 1);
        @(posedge clk);
        #1;
        in_valid = 1'b0;
    endtask

    task automatic drain(input int exp_bin, input int exp_err, input int hold);
        bit ok;
        ok = 1'b0;
        for (int i = 0; i < 50; i++) begin
            @(negedge clk);
            if (out_valid) begin
                ok = 1'b1;
                break;
            end
        end
        if (!ok) check("drain_timeout", 0, 1);
        check("lit_bin", out_bin, exp_bin);
        check("lit_err", out_err, exp_err);
        for (int i = 0; i < hold; i++) begin
            @(negedge clk);
            check("stall_valid", out_valid, 1);
            check("stall_bin", out_bin, exp_bin);
            check("stall_in_ready", in_ready, 0);
        end
        @(posedge clk);
        #1;
        out_ready = 1'b1;
        @(posedge clk);
        #1;
        out_ready = 1'b0;
        @(negedge clk);
        check("idle_after_release", in_ready, 1);
    endtask

    // ------------------------------------------------------------ stimulus
    initial begin
        int first_edge;
        int second_edge;
        bit ok;

        rst       = 1'b1;
        in_valid  = 1'b0;
        out_ready = 1'b0;
        in_trits  = '0;

        // Pin the model to hand-computed values.
        check("model_zero", model_bin(pack5(0, 0, 0, 0, 0)), 0);
        check("model_242",  model_bin(pack5(2, 2, 2, 2, 2)), 242);
        check("model_81",   model_bin(pack5(1, 0, 0, 0, 0)), 81);
        check("model_140",  model_bin(pack5(1, 2, 0, 1, 2)), 140);

        repeat (2) @(negedge clk);
        check("rst_out_bin", out_bin, 0);
        check("rst_out_valid", out_valid, 0);
        check("rst_in_ready", in_ready, 0);
        check("rst_out_err", out_err, 0);
        @(posedge clk);
        #1;
        rst = 1'b0;
        @(negedge clk);
        check("first_cycle_ready", in_ready, 1);

        send(pack5(0, 0, 0, 0, 0));
        drain(0, 0, 0);
        send(pack5(2, 2, 2, 2, 2));
        drain(242, 0, 0);
        send(pack5(1, 0, 0, 0, 0));
        drain(81, 0, 0);
        send(pack5(1, 2, 0, 1, 2));
        drain(140, 0, 10);

        // Trit 3 (value 2) carries the illegal code.
        send(pack5(1, 3, 0, 1, 2));
`ifdef TERN2BIN_ERRCHK_EN
        drain(86, 1, 0);
`else
        drain(140, 0, 0);
`endif

        // Reset two cycles after acceptance discards the word.
        send(pack5(2, 2, 2, 2, 2));
        @(posedge clk);
        #1;
        rst = 1'b1;
        @(posedge clk);
        #1;
        rst = 1'b0;
        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            check("no_valid_after_rst", out_valid, 0);
        end
        send(pack5(1, 2, 0, 1, 2));
        drain(140, 0, 0);

        // Asynchronous reset while DONE clears outputs without an edge.
        send(pack5(1, 0, 0, 0, 0));
        ok = 1'b0;
        for (int i = 0; i < 50; i++) begin
            @(negedge clk);
            if (out_valid) begin
                ok = 1'b1;
                break;
            end
        end
        if (!ok) check("done_timeout", 0, 1);
        #2;
        rst = 1'b1;
        #1;
        check("async_out_valid", out_valid, 0);
        check("async_out_bin", out_bin, 0);
        check("async_in_ready", in_ready, 0);
        @(posedge clk);
        @(posedge clk);
        #1;
        rst = 1'b0;

        // Back-to-back words with the consumer always ready.
        out_ready = 1'b1;
        first_edge  = -1;
        second_edge = -1;
        @(posedge clk);
        #1;
        in_valid = 1'b1;
        in_trits = pack5(0, 0, 1, 1, 1);
        for (int i = 0; i < 50; i++) begin
            @(negedge clk);
            if (in_ready) begin
                first_edge = cyc + 1;
                break;
            end
        end
        @(posedge clk);
        #1;
        in_trits = pack5(2, 0, 1, 0, 2);
        for (int i = 0; i < 50; i++) begin
            @(negedge clk);
            if (in_ready) begin
                second_edge = cyc + 1;
                break;
            end
        end
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        check("b2b_spacing", second_edge - first_edge, NTRIT + 2);
        ok = 1'b0;
        for (int i = 0; i < 50; i++) begin
            @(negedge clk);
            if (q.size() == 0) begin
                ok = 1'b1;
                break;
            end
        end
        if (!ok) check("b2b_drain_timeout", 0, 1);
        check("b2b_last_bin", out_bin, 173);
        out_ready = 1'b0;

        repeat (3) @(negedge clk);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish, %0d tests run, %0d failed", tests, fails);
        $fatal(1, "watchdog");
    end

endmodule : tb_tern2bin
